// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - PC/fetch sequencing, redirect arbitration and pipeline flush control.
// Optional performance counters are enabled with FETCH_CTRL_PERF_EN.
module fetch_ctrl #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    output logic            imem_req,
    input  logic            imem_ready,
    input  logic            ex_redirect,
    input  logic [XLEN-1:0] ex_target,
    input  logic            load_use,
    input  logic            trap,
    input  logic            halt_req,
    output logic            jump_flag,
    output logic [XLEN-1:0] jump_target,
    output logic            stall,
    output logic            flush_if,
    output logic            flush_id,
    output logic            bubble_ex,
`ifdef FETCH_CTRL_PERF_EN
    output logic [31:0]     perf_stall_cycles,
    output logic [31:0]     perf_redirects,
`endif
    output logic            halted
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PEND,
        HALT
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] pend_target;
    logic [XLEN-1:0] pend_next;

    // The fetch address is driven straight from the PC block; pc is only an observer here.
    logic unused_pc;
    assign unused_pc = ^pc;

    always_comb begin
        state_next  = state;
        pend_next   = pend_target;
        imem_req    = 1'b0;
        jump_flag   = 1'b0;
        jump_target = '0;
        stall       = 1'b0;
        flush_if    = 1'b0;
        flush_id    = 1'b0;
        bubble_ex   = 1'b0;
        halted      = 1'b0;
        case (state)
            IDLE: begin
                stall      = 1'b1;
                state_next = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (trap || (!halt_req && ex_redirect)) begin
                    flush_id  = 1'b1;
                    bubble_ex = 1'b1;
                    if (imem_ready) begin
                        jump_flag   = 1'b1;
                        jump_target = trap ? TRAP_VECTOR : ex_target;
                        flush_if    = 1'b1;
                    end else begin
                        // Fetch in flight: the address must not move until the handshake.
                        stall      = 1'b1;
                        pend_next  = trap ? TRAP_VECTOR : ex_target;
                        state_next = PEND;
                    end
                end else if (halt_req) begin
                    stall      = 1'b1;
                    flush_id   = 1'b1;
                    bubble_ex  = 1'b1;
                    state_next = HALT;
                end else if (load_use) begin
                    stall     = 1'b1;
                    bubble_ex = 1'b1;
                end else if (!imem_ready) begin
                    stall    = 1'b1;
                    flush_if = 1'b1;
                end
            end
            PEND: begin
                imem_req = 1'b1;
                flush_if = 1'b1;
                if (trap) begin
                    pend_next = TRAP_VECTOR;
                end
                if (imem_ready) begin
                    jump_flag   = 1'b1;
                    jump_target = trap ? TRAP_VECTOR : pend_target;
                    state_next  = FETCH;
                end else begin
                    stall = 1'b1;
                end
            end
            HALT: begin
                stall    = 1'b1;
                flush_if = 1'b1;
                halted   = 1'b1;
            end
            default: begin
                stall      = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pend_target <= '0;
        end else begin
            state       <= state_next;
            pend_target <= pend_next;
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    logic fetch_stall;
    assign fetch_stall = stall && ((state == FETCH) || (state == PEND));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cycles <= '0;
            perf_redirects    <= '0;
        end else begin
            if (fetch_stall && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (jump_flag && (perf_redirects != 32'hFFFF_FFFF)) begin
                perf_redirects <= perf_redirects + 32'd1;
            end
        end
    end
`endif

endmodule
